// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads to a 1-cycle imem and buffers {instr, pc} in a DEPTH-entry FIFO.
// Request to out_valid is 2 cycles. Issue stops while count+inflight reaches DEPTH; a redirect flushes everything.
module instr_fetch_unit #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [DATAWIDTH-1:0]         imem_addr,
  input  logic [DATAWIDTH-1:0]         imem_rdata,
  input  logic                         redirect_valid,
  input  logic [DATAWIDTH-1:0]         redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATAWIDTH-1:0]         out_instr,
  output logic [DATAWIDTH-1:0]         out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DATAWIDTH-1:0] instr;
    logic [DATAWIDTH-1:0] pc;
  } entry_t;

  logic [DATAWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                 inflight_q, inflight_d;
  logic [DATAWIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  entry_t               mem_q [DEPTH];

  logic [CW:0]          credit_used;
  logic                 push;
  logic                 pop;
  entry_t               head;
  logic                 unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit check ignores a same-cycle pop; gated by rst so nothing is requested while held in reset.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc_q;

  assign push       = inflight_q && !redirect_valid;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign head       = mem_q[rd_ptr_q];
  assign out_instr  = out_valid ? head.instr : '0;
  assign out_pc     = out_valid ? head.pc    : '0;
  assign fifo_count = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[DATAWIDTH-1:2], 2'b00};
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d    = fetch_pc_q + DATAWIDTH'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end else begin
        inflight_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: out_valid gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: imem_rdata, pc: inflight_pc_q};
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q != CW'(DEPTH)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and random checks of instr_fetch_unit against an imem returning addr ^ 32'hA5A5_0000.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_instr, out_instr2, out_pc, out_pc2;
  logic [2:0]  fifo_count, fifo_count2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DATAWIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .fifo_count(fifo_count));

  instr_fetch_unit #(.DATAWIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(out_valid2),
    .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2), .fifo_count(fifo_count2));

  // Synchronous imem; garbage on cycles without a request so stray writes show up.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_req2 ? (imem_addr2 ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst = 1'b0; out_ready = ready; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  logic [31:0] exp_wrap [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  logic [31:0] exp_pc;
  int          delivered;
  logic        redir;

  initial begin
    rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_req",  {31'b0, imem_req},  32'd0);
    check("rst_count",     {29'b0, fifo_count}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc",    out_pc,    32'd0);

    // Streaming from reset, plus the wrapping instance
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("s_req",  {31'b0, imem_req}, 32'd1);
      check("s_addr", imem_addr, 32'(4*k));
      if (k < 2) begin
        check("s_valid_lat", {31'b0, out_valid}, 32'd0);
      end else begin
        check("s_valid", {31'b0, out_valid}, 32'd1);
        check("s_pc",    out_pc, 32'(4*(k-2)));
        check("s_instr", out_instr, 32'(4*(k-2)) ^ 32'hA5A5_0000);
      end
      if (k >= 2 && k < 6) check("wrap_pc", out_pc2, exp_wrap[k-2]);
      step();
    end

    // Stalled decode: fills to DEPTH, then drains in order
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        check("st_req",  {31'b0, imem_req}, 32'd1);
        check("st_addr", imem_addr, 32'(4*k));
      end else begin
        check("st_noreq", {31'b0, imem_req}, 32'd0);
      end
      step();
    end
    check("st_count_full", {29'b0, fifo_count}, 32'd4);
    out_ready = 1'b1;
    #1;
    check("st_credit_ignores_pop", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("dr_valid", {31'b0, out_valid}, 32'd1);
      check("dr_pc",    out_pc, 32'(4*k));
      step();
    end

    // Redirect with 3 buffered and one in flight
    do_reset(1'b0);
    for (int k = 0; k < 4; k++) step();
    check("rd_count_pre", {29'b0, fifo_count}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("rd_noreq", {31'b0, imem_req}, 32'd0);
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rd_count_flush", {29'b0, fifo_count}, 32'd0);
    check("rd_valid_flush", {31'b0, out_valid}, 32'd0);
    check("rd_req",  {31'b0, imem_req}, 32'd1);
    check("rd_addr", imem_addr, 32'h0000_0100);
    step();
    check("rd_valid_c2", {31'b0, out_valid}, 32'd0);
    step();
    check("rd_valid_c3", {31'b0, out_valid}, 32'd1);
    check("rd_pc0",    out_pc, 32'h0000_0100);
    check("rd_instr0", out_instr, 32'hA5A5_0100);
    step();
    check("rd_pc1", out_pc, 32'h0000_0104);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_pc = 32'h0000_0306;
    step();
    redirect_valid = 1'b0;
    #1;
    check("b2b_addr",  imem_addr, 32'h0000_0304);
    check("b2b_count", {29'b0, fifo_count}, 32'd0);
    step();
    step();
    check("b2b_valid", {31'b0, out_valid}, 32'd1);
    check("b2b_pc",    out_pc, 32'h0000_0304);

    // Asynchronous reset between edges with a full FIFO
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) step();
    check("ar_full", {29'b0, fifo_count}, 32'd4);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_req",   {31'b0, imem_req},  32'd0);
    check("ar_count", {29'b0, fifo_count}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1; rst = 1'b1;
    #1;
    check("ar_restart_req",  {31'b0, imem_req}, 32'd1);
    check("ar_restart_addr", imem_addr, 32'h0000_0000);
    step();
    step();
    check("ar_restart_pc", out_pc, 32'h0000_0000);

    // Random ready and redirects against a sequential-PC scoreboard
    do_reset(1'b1);
    exp_pc = 32'h0; delivered = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      out_ready      = 1'($urandom_range(0, 1));
      redir          = ($urandom_range(0, 31) == 0);
      redirect_valid = redir;
      redirect_pc    = $urandom & 32'h0000_FFFF;
      #1;
      if (redir) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (out_valid && out_ready) begin
        check("rnd_pc",    out_pc, exp_pc);
        check("rnd_instr", out_instr, exp_pc ^ 32'hA5A5_0000);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
    end
    redirect_valid = 1'b0;
    check("rnd_throughput", {31'b0, (delivered >= 2000)}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage upstream of instruction decode/split.
- Owns the fetch PC and issues word requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, tagged with their PC, in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts a redirect from branch/jump resolution that flushes all buffered and in-flight work.

Parameters:
- DATAWIDTH, 32, width of PC, address and instruction.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- imem_req  output  1  read request this cycle.
- imem_addr  output  DATAWIDTH  word-aligned read address; valid when imem_req=1.
- imem_rdata  input  DATAWIDTH  read data, valid the cycle after imem_req.
- redirect_valid  input  1  pulse: restart fetch at redirect_pc.
- redirect_pc  input  DATAWIDTH  new fetch address; bits [1:0] are ignored and forced to 0.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  DATAWIDTH  instruction at the FIFO head.
- out_pc  output  DATAWIDTH  PC of out_instr.
- fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- State:
  - fetch_pc register.
  - inflight flag: a request was issued last cycle and has not been killed.
  - inflight_pc register.
  - DEPTH-entry FIFO of {instr, pc}, with read pointer, write pointer and count.
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, inflight=0, count=0, pointers=0.
  - out_valid=0, imem_req=0, out_instr=0, out_pc=0, fifo_count=0.
  - Applies immediately, including mid-operation; all buffered and in-flight data is lost.
- Issue: imem_req = !redirect_valid && (count + inflight < DEPTH).
  - The credit check deliberately ignores a same-cycle pop, so the FIFO can never overflow.
  - imem_addr=fetch_pc (combinational from the register).
  - On issue: fetch_pc <= fetch_pc+4, modulo 2^DATAWIDTH (32'hFFFF_FFFC wraps to 0); inflight <= 1; inflight_pc <= fetch_pc.
  - No issue: inflight <= 0.
- Response: in the cycle where inflight=1 and no redirect, {imem_rdata, inflight_pc} is written at the write pointer at the clock edge.
- Output:
  - out_valid = (count != 0); out_instr and out_pc come from the head entry.
  - Pop when out_valid && out_ready; the read pointer advances.
  - out_instr and out_pc hold steady while out_valid=1 and out_ready=0.
- Latency, no stalls: request issued in cycle N; data returns in cycle N+1 and is written at that edge; out_valid=1 in cycle N+2.
  - No bypass path.
  - Steady-state throughput is 1 instruction/cycle when out_ready stays 1.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Push when count==DEPTH cannot occur (credit rule). Assertion: flag any write while full.
- Redirect (redirect_valid=1) has priority over everything in that cycle:
  - FIFO cleared: count=0, pointers=0. A pop that cycle is discarded.
  - The in-flight response arriving that cycle is discarded; inflight <= 0.
  - No request is issued that cycle.
  - fetch_pc <= {redirect_pc[DATAWIDTH-1:2], 2'b00}.
  - Next cycle issues at the redirect target (if the credit rule allows; after a flush it always does).
  - out_valid is 0 the cycle after redirect; the first redirected instruction appears 3 cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; each flushes again.
- Stalled decode (out_ready=0): FIFO fills to DEPTH, then imem_req stays 0 until a pop frees a credit. No instruction is lost or duplicated.

Test Plan:
- Reset release with imem returning rdata = addr ^ 32'hA5A5_0000, out_ready=1 → imem_addr 0,4,8,... on consecutive cycles; first out_valid 2 cycles after the first request with out_pc=0, out_instr=32'hA5A5_0000; then one instruction per cycle in PC order.
- Hold out_ready=0 from reset for 10 cycles → fifo_count reaches 4; exactly 4 requests issued (0,4,8,C); imem_req then stays 0; after releasing out_ready, PCs 0,4,8,C,10 are delivered with no gaps or duplicates.
- Redirect to 32'h0000_0103 while the FIFO holds 3 entries and a request is in flight → fifo_count=0 the next cycle; the stale response never appears; the next imem_addr is 32'h0000_0100; the first out_pc after redirect is 32'h0000_0100.
- RESET_PC=32'hFFFF_FFF8, out_ready=1 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Drive rst=0 asynchronously mid-stream, between clock edges, with a full FIFO → out_valid, imem_req and fifo_count drop to 0 immediately without a clock edge; after release, fetch restarts at RESET_PC.
- Random out_ready (50%) plus random redirects over 10k cycles → scoreboard: every delivered {pc, instr} matches memory, PCs are sequential between redirects, and no FIFO overflow assertion fires.
